// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Power-up and recovery reset sequencer for a dual-MMCM clocking block.
//   Holds both MMCMs in reset and then waits for both to lock. It requires
//   the locks to stay up for a stable window. It then releases three
//   downstream reset domains in ascending order, one gap apart. A lock
//   timeout retries the MMCM reset. After MAX_RETRIES timeouts the block
//   parks in a fault state until a software or hardware reset.
//
// Ports
//   clkIn        in   1  free-running board reference clock (sole clock)
//   rstNIn       in   1  asynchronous active-low reset
//   lockedIn     in   2  MMCM locked flags (bit0 mmcm0, bit1 mmcm1), async
//   swRstIn      in   1  synchronous software reset request, level, active-high
//   mmcmRstOut   out  1  reset to both MMCMs, active-high
//   rstStageOut  out  3  domain resets: bit0 PHY, bit1 parser, bit2 book builder
//   readyOut     out  1  all stages released
//   faultOut     out  1  retry limit exhausted
//   retryCntOut  out  4  lock timeouts since last reset / software reset
//
// All outputs are registered from next-state values, so they change only on
// clkIn edges (or asynchronously on rstNIn assertion) and never glitch.

module rst_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 64,
  parameter int unsigned STAGE_GAP_CYCLES    = 16,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clkIn,
  input  logic       rstNIn,
  input  logic [1:0] lockedIn,
  input  logic       swRstIn,
  output logic       mmcmRstOut,
  output logic [2:0] rstStageOut,
  output logic       readyOut,
  output logic       faultOut,
  output logic [3:0] retryCntOut
);

  // One shared phase counter, wide enough for the longest interval plus a
  // guard bit so it can never wrap.
  localparam int unsigned MAX_A   = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_B   = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                                    LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int          CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAULT
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [3:0]    retry_next, retry_inc;
  logic [2:0]    stage_next;
  logic          ready_next;

  // ---------------------------------------------------------------------------
  // Reset release synchronizer: assertion is immediate, release is seen two
  // clkIn edges later so the FSM never leaves HOLD on a metastable release.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       run_en;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run_en = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Lock flag synchronizer, two flops per bit.
  // ---------------------------------------------------------------------------
  logic [1:0] lock_meta;
  logic [1:0] lock_sync;
  logic       locked;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      lock_meta <= '0;
      lock_sync <= '0;
    end else begin
      lock_meta <= lockedIn;
      lock_sync <= lock_meta;
    end
  end

  assign locked = &lock_sync;

  // Saturating increments; transitions happen well before saturation.
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CW'(1);
  assign retry_inc = (retryCntOut == 4'hF) ? 4'hF : retryCntOut + 4'd1;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // Default output view is "everything in reset, not ready"; only the
  // RELEASE/RUN paths lower stage bits, which keeps release order ascending
  // and makes any lock loss re-assert all stages on the next edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    retry_next = retryCntOut;
    stage_next = 3'b111;
    ready_next = 1'b0;

    if (!run_en) begin
      state_next = HOLD;
      cnt_next   = '0;
    end else if (swRstIn) begin
      state_next = HOLD;
      cnt_next   = '0;
      retry_next = '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end

        WAIT_LOCK: begin
          if (locked) begin
            // The cycle that observed lock counts as the first stable cycle.
            state_next = STABLE;
            cnt_next   = CW'(1);
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_next   = '0;
            retry_next = retry_inc;
            state_next = (32'(retry_inc) < MAX_RETRIES) ? HOLD : FAULT;
          end else begin
            cnt_next = cnt_inc;
          end
        end

        STABLE: begin
          if (!locked) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt >= STABLE_LAST) begin
            state_next = RELEASE;
            cnt_next   = '0;
            stage_next = 3'b110;
          end else begin
            cnt_next = cnt_inc;
          end
        end

        RELEASE: begin
          if (!locked) begin
            state_next = HOLD;
            cnt_next   = '0;
          end else if (cnt == GAP_LAST) begin
            cnt_next = '0;
            if (rstStageOut[1]) begin
              stage_next = 3'b100;
            end else begin
              state_next = RUN;
              stage_next = 3'b000;
              ready_next = 1'b1;
            end
          end else begin
            cnt_next   = cnt_inc;
            stage_next = rstStageOut;
          end
        end

        RUN: begin
          if (!locked) begin
            state_next = HOLD;
            cnt_next   = '0;
          end else begin
            stage_next = 3'b000;
            ready_next = 1'b1;
          end
        end

        FAULT: begin
          state_next = FAULT;
        end

        default: begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state       <= HOLD;
      cnt         <= '0;
      mmcmRstOut  <= 1'b1;
      rstStageOut <= 3'b111;
      readyOut    <= 1'b0;
      faultOut    <= 1'b0;
      retryCntOut <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      mmcmRstOut  <= (state_next == HOLD) || (state_next == FAULT);
      rstStageOut <= stage_next;
      readyOut    <= ready_next;
      faultOut    <= (state_next == FAULT);
      retryCntOut <= retry_next;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer
//   Self-checking bench for rst_sequencer. It runs a table of timed vectors
//   and a few hand-written corner sequences. A randomized lock/soft-reset
//   phase follows. A time-based reference model is compared against the
//   DUT outputs on every falling clock edge.

module tb_rst_sequencer;

  localparam int HOLD_N  = 8;
  localparam int TMO_N   = 1000;
  localparam int STB_N   = 64;
  localparam int GAP_N   = 16;
  localparam int RETRY_N = 3;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic [1:0] locked = 2'b00;
  logic       sw_rst = 1'b0;

  logic       mmcm_rst;
  logic [2:0] stage;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [9:0] dut_out;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int cur      = 0;

  rst_sequencer #(
    .RST_HOLD_CYCLES    (HOLD_N),
    .LOCK_TIMEOUT_CYCLES(TMO_N),
    .LOCK_STABLE_CYCLES (STB_N),
    .STAGE_GAP_CYCLES   (GAP_N),
    .MAX_RETRIES        (RETRY_N)
  ) dut (
    .clkIn      (clk),
    .rstNIn     (rst_n),
    .lockedIn   (locked),
    .swRstIn    (sw_rst),
    .mmcmRstOut (mmcm_rst),
    .rstStageOut(stage),
    .readyOut   (ready),
    .faultOut   (fault),
    .retryCntOut(retry_cnt)
  );

  assign dut_out = {mmcm_rst, stage, ready, fault, retry_cnt};

  always #5 clk = ~clk;

  function automatic logic [9:0] pack(logic m, logic [2:0] s, logic r, logic f, logic [3:0] c);
    return {m, s, r, f, c};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got {mmcm,stage,ready,fault,retry}=%b expected %b",
               name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: mode plus time spent in it. Stage outputs are derived
  // from elapsed release time; lock is the input as seen two edges ago.
  // ---------------------------------------------------------------------------
  localparam int M_HOLD = 0, M_WAIT = 1, M_STABLE = 2, M_REL = 3, M_RUN = 4, M_FAULT = 5;
  int         age     = 0;
  int         mode    = M_HOLD;
  int         t       = 0;
  int         retries = 0;
  logic [1:0] h1      = '0;
  logic [1:0] h2      = '0;
  bit         seen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age = 0; mode = M_HOLD; t = 0; retries = 0; h1 = '0; h2 = '0;
    end else begin
      seen = (h2 == 2'b11);
      h2 = h1;
      h1 = locked;
      if (age < 2) begin
        age++;
      end else if (sw_rst) begin
        mode = M_HOLD; t = 0; retries = 0;
      end else begin
        case (mode)
          M_HOLD: begin
            t++;
            if (t == HOLD_N) begin mode = M_WAIT; t = 0; end
          end
          M_WAIT: begin
            if (seen) begin
              mode = M_STABLE; t = 1;
            end else begin
              t++;
              if (t == TMO_N) begin
                retries = (retries < 15) ? retries + 1 : 15;
                mode = (retries < RETRY_N) ? M_HOLD : M_FAULT;
                t = 0;
              end
            end
          end
          M_STABLE: begin
            if (!seen) begin
              mode = M_WAIT; t = 0;
            end else begin
              t++;
              if (t == STB_N) begin mode = M_REL; t = 0; end
            end
          end
          M_REL: begin
            if (!seen) begin
              mode = M_HOLD; t = 0;
            end else begin
              t++;
              if (t == 2 * GAP_N) mode = M_RUN;
            end
          end
          M_RUN: begin
            if (!seen) begin mode = M_HOLD; t = 0; end
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [9:0] model_out();
    logic [2:0] s;
    s = 3'b111;
    if (mode == M_REL) s = (t < GAP_N) ? 3'b110 : 3'b100;
    else if (mode == M_RUN) s = 3'b000;
    return pack(mode == M_HOLD || mode == M_FAULT, s, mode == M_RUN, mode == M_FAULT, 4'(retries));
  endfunction

  always @(negedge clk) begin
    if (chk_en) check("model_cycle", dut_out, model_out());
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_out, pack(1'b1, 3'b111, 1'b0, 1'b0, 4'd0));
    chk_en = 1'b1;
    locked = 2'b00;
    sw_rst = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cur = 0;
  endtask

  task automatic adv_to(input int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  // k counts falling edges since rstNIn release; check at k, then apply inputs.
  typedef struct {
    bit         restart;
    int         k;
    logic [1:0] lock;
    logic       sw;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit rs, int k, logic [1:0] lk, logic sw, logic m, logic [2:0] s,
                     logic r, logic f, logic [3:0] c);
    vec_t v;
    v.restart = rs; v.k = k; v.lock = lk; v.sw = sw; v.exp = pack(m, s, r, f, c);
    vecs.push_back(v);
  endtask

  initial begin
    int         len;
    int         r;
    logic [1:0] base;

    // Nominal bring-up, then lock loss in RUN.
    add(1,    0, 2'b00, 0, 1, 3'b111, 0, 0, 0);
    add(0,    9, 2'b00, 0, 1, 3'b111, 0, 0, 0);
    add(0,   10, 2'b00, 0, 0, 3'b111, 0, 0, 0);
    add(0,   20, 2'b11, 0, 0, 3'b111, 0, 0, 0);
    add(0,   85, 2'b11, 0, 0, 3'b111, 0, 0, 0);
    add(0,   86, 2'b11, 0, 0, 3'b110, 0, 0, 0);
    add(0,  101, 2'b11, 0, 0, 3'b110, 0, 0, 0);
    add(0,  102, 2'b11, 0, 0, 3'b100, 0, 0, 0);
    add(0,  117, 2'b11, 0, 0, 3'b100, 0, 0, 0);
    add(0,  118, 2'b11, 0, 0, 3'b000, 1, 0, 0);
    add(0,  130, 2'b10, 0, 0, 3'b000, 1, 0, 0);
    add(0,  132, 2'b10, 0, 0, 3'b000, 1, 0, 0);
    add(0,  133, 2'b10, 0, 1, 3'b111, 0, 0, 0);
    add(0,  140, 2'b10, 0, 1, 3'b111, 0, 0, 0);
    add(0,  141, 2'b10, 0, 0, 3'b111, 0, 0, 0);
    // Three lock timeouts, fault, software reset recovery.
    add(1,    0, 2'b00, 0, 1, 3'b111, 0, 0, 0);
    add(0, 1009, 2'b00, 0, 0, 3'b111, 0, 0, 0);
    add(0, 1010, 2'b00, 0, 1, 3'b111, 0, 0, 1);
    add(0, 2017, 2'b00, 0, 0, 3'b111, 0, 0, 1);
    add(0, 2018, 2'b00, 0, 1, 3'b111, 0, 0, 2);
    add(0, 3025, 2'b00, 0, 0, 3'b111, 0, 0, 2);
    add(0, 3026, 2'b00, 0, 1, 3'b111, 0, 1, 3);
    add(0, 3040, 2'b00, 1, 1, 3'b111, 0, 1, 3);
    add(0, 3041, 2'b00, 0, 1, 3'b111, 0, 0, 0);
    add(0, 3048, 2'b00, 0, 1, 3'b111, 0, 0, 0);
    add(0, 3049, 2'b00, 0, 0, 3'b111, 0, 0, 0);
    // One-cycle glitch on lock bit1 during the stable window.
    add(1,    0, 2'b00, 0, 1, 3'b111, 0, 0, 0);
    add(0,   20, 2'b11, 0, 0, 3'b111, 0, 0, 0);
    add(0,   60, 2'b01, 0, 0, 3'b111, 0, 0, 0);
    add(0,   61, 2'b11, 0, 0, 3'b111, 0, 0, 0);
    add(0,   90, 2'b11, 0, 0, 3'b111, 0, 0, 0);
    add(0,  126, 2'b11, 0, 0, 3'b111, 0, 0, 0);
    add(0,  127, 2'b11, 0, 0, 3'b110, 0, 0, 0);
    // Software reset on the edge where stage bit1 would release.
    add(1,    0, 2'b00, 0, 1, 3'b111, 0, 0, 0);
    add(0, 1010, 2'b00, 0, 1, 3'b111, 0, 0, 1);
    add(0, 1020, 2'b11, 0, 0, 3'b111, 0, 0, 1);
    add(0, 1086, 2'b11, 0, 0, 3'b110, 0, 0, 1);
    add(0, 1101, 2'b11, 1, 0, 3'b110, 0, 0, 1);
    add(0, 1102, 2'b11, 1, 1, 3'b111, 0, 0, 0);
    add(0, 1104, 2'b11, 0, 1, 3'b111, 0, 0, 0);
    add(0, 1111, 2'b11, 0, 1, 3'b111, 0, 0, 0);
    add(0, 1112, 2'b11, 0, 0, 3'b111, 0, 0, 0);

    #1 rst_n = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].restart) do_reset();
      adv_to(vecs[i].k);
      check($sformatf("vec%0d_k%0d", i, vecs[i].k), dut_out, vecs[i].exp);
      locked = vecs[i].lock;
      sw_rst = vecs[i].sw;
    end

    // Asynchronous reset in the middle of RELEASE, observed between edges.
    do_reset();
    locked = 2'b11;
    adv_to(73);
    check("pre_release", dut_out, pack(1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    adv_to(80);
    check("in_release", dut_out, pack(1'b0, 3'b110, 1'b0, 1'b0, 4'd0));
    #2 rst_n = 1'b0;
    #1 check("mid_release_reset", dut_out, pack(1'b1, 3'b111, 1'b0, 1'b0, 4'd0));

    // Randomized lock behaviour, soft resets and occasional hard resets.
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 99);
      base = (r < 55) ? 2'b11 : 2'($urandom_range(0, 3));
      len = (r >= 92) ? $urandom_range(1000, 1300) : $urandom_range(1, 150);
      sw_rst = ($urandom_range(0, 99) < 8);
      locked = base;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        sw_rst = 1'b0;
        locked = ($urandom_range(0, 99) < 2) ? base ^ 2'($urandom_range(1, 3)) : base;
      end
      if ($urandom_range(0, 99) < 5) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #4000000;
    failures++;
    $display("FAIL watchdog: run exceeded its time budget, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time budget exceeded");
  end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 8: cycles mmcmRstOut is held high per MMCM reset attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1000: cycles allowed for both locks after MMCM reset release.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 64: consecutive cycles both locks must stay high before reset release begins.
REQ-004 SHALL have parameter STAGE_GAP_CYCLES, default 16: cycles between successive stage reset releases.
REQ-005 SHALL have parameter MAX_RETRIES, default 3: lock timeouts tolerated before fault.
REQ-006 clkIn  input  1  free-running board reference clock; sole clock.
REQ-007 rstNIn  input  1  reset, asynchronous, active-low.
REQ-008 lockedIn  input  2  MMCM locked flags, bit0 = mmcm0, bit1 = mmcm1; asynchronous to clkIn.
REQ-009 swRstIn  input  1  synchronous software reset request, active-high, level.
REQ-010 mmcmRstOut  output  1  reset to both MMCMs, active-high.
REQ-011 rstStageOut  output  3  active-high domain reset requests; bit0 = tx/rx PHY domains, bit1 = 250MHz parser domain, bit2 = book builder.
REQ-012 readyOut  output  1  high when all stages are released.
REQ-013 faultOut  output  1  high when the retry limit is exhausted.
REQ-014 retryCntOut  output  4  number of lock timeouts since the last reset or swRstIn.

Function
REQ-015 lockedIn SHALL pass through a 2-FF synchronizer per bit; "locked" below means both synchronized bits are high.
REQ-016 The FSM SHALL have states HOLD, WAIT_LOCK, STABLE, RELEASE, RUN and FAULT.
REQ-017 HOLD: mmcmRstOut = 1, all rstStageOut = 1; after RST_HOLD_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: mmcmRstOut = 0, all stages = 1.
  - locked -> STABLE, stable counter cleared.
  - counter reaches LOCK_TIMEOUT_CYCLES without lock -> retryCntOut += 1; then -> HOLD if new count < MAX_RETRIES, else -> FAULT.
REQ-019 STABLE: any cycle not locked -> WAIT_LOCK, timeout counter restarted; LOCK_STABLE_CYCLES consecutive locked cycles -> RELEASE.
REQ-020 RELEASE:
  - rstStageOut[0] SHALL drop on the first RELEASE cycle.
  - bit1 SHALL drop STAGE_GAP_CYCLES later, bit2 STAGE_GAP_CYCLES after bit1.
  - -> RUN in the cycle bit2 drops.
REQ-021 Stage bits SHALL release only in ascending order; a released bit stays low until a return to HOLD or WAIT_LOCK.
REQ-022 RUN: readyOut = 1 and rstStageOut = 3'b000, registered with no glitch.
REQ-023 Lock loss in RELEASE or RUN SHALL set all stage bits to 1 in the next cycle, clear readyOut and go to HOLD; retryCntOut is unchanged.
REQ-024 FAULT: mmcmRstOut = 1, all stages = 1, faultOut = 1; terminal until swRstIn or rstNIn.
REQ-025 swRstIn high in any state SHALL force HOLD next cycle with all counters and retryCntOut cleared, and hold HOLD while it stays high.
REQ-026 swRstIn has priority over lock events in the same cycle; lock loss has priority over stage advance.
REQ-027 retryCntOut SHALL saturate at 15.
REQ-028 Counters SHALL be sized with $clog2 of their largest parameter plus one bit, and SHALL never wrap.
REQ-029 All outputs SHALL be driven directly from flops.

Reset
REQ-030 While rstNIn = 0: state = HOLD, mmcmRstOut = 1, rstStageOut = 3'b111, readyOut = 0, faultOut = 0, retryCntOut = 0, all counters and synchronizers = 0.
REQ-031 Reset assertion SHALL take effect asynchronously.
REQ-032 Reset deassertion SHALL be used through an internal 2-FF release synchronizer; the HOLD count starts on the first clkIn edge after synchronized release.

Verification
REQ-033 Nominal: release rstNIn, lockedIn = 2'b11 at cycle 20.
  - Required: mmcmRstOut low after 8 HOLD cycles.
  - Required: bit0 drops 2+64 cycles after lock; bit1 drops 16 cycles later; bit2 drops 16 cycles after that; readyOut = 1.
REQ-034 Timeout: lockedIn held 2'b00.
  - Required: retryCntOut steps 1, 2, 3 at 1008-cycle intervals.
  - Required: faultOut = 1 and mmcmRstOut = 1 after the third timeout; swRstIn pulse clears both.
REQ-035 Glitch in STABLE: lockedIn[1] low for 1 cycle at stable count 40.
  - Required: return to WAIT_LOCK, and release occurs only after a fresh 64-cycle stable window.
REQ-036 Lock loss in RUN: drop lockedIn[0].
  - Required: rstStageOut = 3'b111 and readyOut = 0 within 3 cycles, HOLD re-entered, retryCntOut unchanged.
REQ-037 Simultaneous events: swRstIn asserted in the same cycle stage bit1 would release.
  - Required: bit1 stays 1, HOLD entered, retryCntOut = 0.
REQ-038 Mid-operation reset: rstNIn low during RELEASE.
  - Required: all outputs take reset values with no clkIn edge.
